// File: rtl/ulpb_tx_node.sv
// rtl/ulpb_tx_node.sv - ULPB ring-bus transmit node: arbitration, address/word serialiser, ACK window.
// Optional macro ULPB_TX_PARITY_EN appends an even-parity bit after every data word.
module ulpb_tx_node #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int ACK_TIMEOUT  = 16,
    parameter int BITCNT_WIDTH = $clog2((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_in,
    output logic                  o_out,
    input  logic                  i_req_tx,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    input  logic                  i_tx_last,
    output logic                  o_tx_ready,
    output logic                  o_tx_done,
    output logic                  o_tx_acked,
    output logic                  o_tx_fail,
    output logic                  o_busy
);

    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARB,
        S_ADDR_DRIVE,
        S_ADDR_LATCH,
        S_DATA_DRIVE,
        S_DATA_LATCH,
        S_END_OF_TX,
        S_WAIT_ACK,
        S_FWD,
        S_BUS_RESET
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_fetch;
    logic                    r_bit_out;
    logic [BITCNT_WIDTH-1:0] r_bitpos;
    logic [ACK_W-1:0]        r_ack_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr_sh;
    logic [DATA_WIDTH-1:0]   r_word_sh;
    logic                    r_last;
    logic                    r_acked;
    logic                    r_fail;
    logic                    r_tx_done;
    logic                    r_in_hi;
`ifdef ULPB_TX_PARITY_EN
    logic                    r_par;
    logic                    r_par_phase;
`endif

    always_comb begin
        w_next  = r_state;
        w_fetch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_tx)
                    w_next = S_ARB;
                else if (!i_in)
                    w_next = S_FWD;
            end
            S_ARB:        w_next = i_in ? S_ADDR_DRIVE : S_FWD;
            S_ADDR_DRIVE: w_next = S_ADDR_LATCH;
            S_ADDR_LATCH: begin
                if (r_bitpos != '0)
                    w_next = S_ADDR_DRIVE;
                else
                    w_fetch = 1'b1;
            end
            S_DATA_DRIVE: w_next = S_DATA_LATCH;
            S_DATA_LATCH: begin
                if (r_bitpos != '0)
                    w_next = S_DATA_DRIVE;
`ifdef ULPB_TX_PARITY_EN
                else if (!r_par_phase)
                    w_next = S_DATA_DRIVE;
`endif
                else if (r_last)
                    w_next = S_END_OF_TX;
                else
                    w_fetch = 1'b1;
            end
            S_END_OF_TX:  w_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!i_in || (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1)))
                    w_next = S_BUS_RESET;
            end
            S_FWD: begin
                if (i_in && r_in_hi)
                    w_next = S_BUS_RESET;
            end
            S_BUS_RESET:  w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
        // A fetch with no word available aborts straight to the end marker.
        if (w_fetch)
            w_next = i_tx_valid ? S_DATA_DRIVE : S_END_OF_TX;
    end

    always_comb begin
        o_out = r_bit_out;
        case (r_state)
            S_IDLE:      o_out = i_in & ~i_req_tx;
            S_FWD:       o_out = i_in;
            S_END_OF_TX: o_out = 1'b0;
            S_WAIT_ACK:  o_out = 1'b1;
            S_BUS_RESET: o_out = 1'b1;
            default:     o_out = r_bit_out;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_bit_out   <= 1'b1;
            r_bitpos    <= '0;
            r_ack_cnt   <= '0;
            r_addr_sh   <= '0;
            r_word_sh   <= '0;
            r_last      <= 1'b0;
            r_acked     <= 1'b0;
            r_fail      <= 1'b0;
            r_tx_done   <= 1'b0;
            r_in_hi     <= 1'b0;
`ifdef ULPB_TX_PARITY_EN
            r_par       <= 1'b0;
            r_par_phase <= 1'b0;
`endif
        end else begin
            r_state   <= w_next;
            r_tx_done <= 1'b0;
            r_in_hi   <= (r_state == S_FWD) && i_in;
            case (r_state)
                S_IDLE: r_bit_out <= 1'b1;
                S_ARB: begin
                    if (i_in) begin
                        r_addr_sh   <= i_addr;
                        r_bit_out   <= i_addr[ADDR_WIDTH-1];
                        r_bitpos    <= BITCNT_WIDTH'(ADDR_WIDTH - 1);
                        r_acked     <= 1'b0;
                        r_fail      <= 1'b0;
`ifdef ULPB_TX_PARITY_EN
                        r_par_phase <= 1'b0;
`endif
                    end
                end
                S_ADDR_LATCH: begin
                    if (r_bitpos != '0) begin
                        r_bitpos  <= r_bitpos - BITCNT_WIDTH'(1);
                        r_bit_out <= r_addr_sh[ADDR_WIDTH-2];
                        r_addr_sh <= r_addr_sh << 1;
                    end
                end
                S_DATA_LATCH: begin
                    if (r_bitpos != '0) begin
                        r_bitpos  <= r_bitpos - BITCNT_WIDTH'(1);
                        r_bit_out <= r_word_sh[DATA_WIDTH-2];
                        r_word_sh <= r_word_sh << 1;
                    end
`ifdef ULPB_TX_PARITY_EN
                    else if (!r_par_phase) begin
                        r_bit_out   <= r_par;
                        r_par_phase <= 1'b1;
                    end
`endif
                end
                S_END_OF_TX: r_ack_cnt <= '0;
                S_WAIT_ACK: begin
                    if (!i_in) begin
                        r_acked   <= 1'b1;
                        r_tx_done <= 1'b1;
                    end else if (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                        r_fail    <= 1'b1;
                        r_tx_done <= 1'b1;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + ACK_W'(1);
                    end
                end
                S_BUS_RESET: r_bit_out <= 1'b1;
                default: ;
            endcase
            if (w_fetch) begin
                if (i_tx_valid) begin
                    r_word_sh   <= i_tx_data;
                    r_last      <= i_tx_last;
                    r_bit_out   <= i_tx_data[DATA_WIDTH-1];
                    r_bitpos    <= BITCNT_WIDTH'(DATA_WIDTH - 1);
`ifdef ULPB_TX_PARITY_EN
                    r_par       <= ^i_tx_data;
                    r_par_phase <= 1'b0;
`endif
                end else begin
                    r_fail <= 1'b1;
                end
            end
        end
    end

    assign o_tx_ready = w_fetch;
    assign o_tx_done  = r_tx_done;
    // An underflowed transfer reports failure even if the receiver still acked.
    assign o_tx_acked = r_tx_done & r_acked & ~r_fail;
    assign o_tx_fail  = r_tx_done & r_fail;
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ulpb_tx_node.sv
// tb/tb_ulpb_tx_node.sv - directed self-checking bench for ulpb_tx_node (default build, no parity).
module tb_ulpb_tx_node;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_b;
    logic        out_b;
    logic        req;
    logic [7:0]  addr;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        ready;
    logic        done;
    logic        acked;
    logic        fail;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        cap [0:299];
    logic [31:0] wq  [0:3];

    always #5 clk = ~clk;

    ulpb_tx_node #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .ACK_TIMEOUT(16)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_in      (in_b),
        .o_out     (out_b),
        .i_req_tx  (req),
        .i_addr    (addr),
        .i_tx_data (tx_data),
        .i_tx_valid(tx_valid),
        .i_tx_last (tx_last),
        .o_tx_ready(ready),
        .o_tx_done (done),
        .o_tx_acked(acked),
        .o_tx_fail (fail),
        .o_busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic vec(input string tag, input logic i, input logic r, input logic e_out, input logic e_busy);
        in_b = i;
        req  = r;
        @(negedge clk);
        check({tag, "_out"}, 32'(out_b), 32'(e_out));
        check({tag, "_busy"}, 32'(busy), 32'(e_busy));
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is IDLE with REQ_TX high, cycle 1 is ARB, address bits start at cycle 2.
    task automatic do_tx(input logic [7:0] a, input int nw, input int ack_pos, input bit uflow);
        int          n_exp;
        int          eot;
        int          ack_k;
        int          widx;
        int          nrdy;
        int          rdy0;
        int          rdy1;
        int          ndone;
        int          done_k;
        logic        d_ack;
        logic        d_fail;
        logic        fire;
        logic        exp_ack;
        logic [7:0]  ga;
        logic [7:0]  gah;
        logic [31:0] gw;
        logic [31:0] gwh;
        n_exp  = uflow ? 0 : nw;
        eot    = 2 + 16 + 64 * n_exp;
        ack_k  = (ack_pos > 0) ? eot + ack_pos : -1;
        widx   = 0;
        nrdy   = 0;
        rdy0   = -1;
        rdy1   = -1;
        ndone  = 0;
        done_k = -1;
        d_ack  = 1'b0;
        d_fail = 1'b0;
        addr   = a;
        req    = 1'b1;
        for (int k = 0; k < 300 && ndone == 0; k++) begin
            in_b     = (k == ack_k) ? 1'b0 : 1'b1;
            tx_valid = !uflow;
            tx_data  = wq[widx];
            tx_last  = (widx == nw - 1);
            @(negedge clk);
            cap[k] = out_b;
            fire   = ready && tx_valid;
            if (ready) begin
                if (nrdy == 0) rdy0 = k;
                else if (nrdy == 1) rdy1 = k;
                nrdy++;
            end
            if (done) begin
                ndone++;
                done_k = k;
                d_ack  = acked;
                d_fail = fail;
            end
            @(posedge clk);
            #1;
            if (fire && widx < nw - 1) widx++;
        end
        req      = 1'b0;
        in_b     = 1'b1;
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ga[7-i]  = cap[2 + 2*i];
            gah[7-i] = cap[3 + 2*i];
        end
        check("addr", 32'(ga), 32'(a));
        check("addr_hold", 32'(gah), 32'(a));
        for (int w = 0; w < n_exp; w++) begin
            for (int j = 0; j < 32; j++) begin
                gw[31-j]  = cap[18 + 64*w + 2*j];
                gwh[31-j] = cap[19 + 64*w + 2*j];
            end
            check("word", gw, wq[w]);
            check("word_hold", gwh, wq[w]);
        end
        exp_ack = (ack_pos > 0) && !uflow;
        check("eot_out", 32'(cap[eot]), 32'd0);
        check("wait_out", 32'(cap[eot + 1]), 32'd1);
        check("ready_cnt", nrdy, uflow ? 1 : nw);
        check("ready_first", rdy0, 17);
        if (nrdy >= 2) check("ready_gap", rdy1 - rdy0, 64);
        check("done_cnt", ndone, 1);
        check("done_cyc", done_k, (ack_pos > 0) ? eot + ack_pos + 1 : eot + 1 + 16);
        check("acked", 32'(d_ack), 32'(exp_ack));
        check("fail", 32'(d_fail), 32'(!exp_ack));
    endtask

    int ndone_rst;

    initial begin
        rst      = 1'b1;
        in_b     = 1'b1;
        req      = 1'b0;
        addr     = 8'h00;
        tx_data  = 32'h0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_acked", 32'(acked), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_out", 32'(out_b), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // idle pass-through: IDLE, IDLE->FWD, FWD, FWD->BUS_RESET, BUS_RESET, IDLE
        vec("pt0", 1'b1, 1'b0, 1'b1, 1'b0);
        vec("pt1", 1'b0, 1'b0, 1'b0, 1'b0);
        vec("pt2", 1'b1, 1'b0, 1'b1, 1'b1);
        vec("pt3", 1'b1, 1'b0, 1'b1, 1'b1);
        vec("pt4", 1'b0, 1'b0, 1'b1, 1'b1);
        vec("pt5", 1'b1, 1'b0, 1'b1, 1'b0);

        wq[0] = 32'hDEADBEEF;
        do_tx(8'hA5, 1, 3, 1'b0);

        wq[0] = 32'h00000001;
        wq[1] = 32'h00000002;
        wq[2] = 32'h80000000;
        do_tx(8'h5A, 3, 1, 1'b0);

        wq[0] = 32'h0F0F1234;
        do_tx(8'hC3, 1, 0, 1'b0);

        // lost arbitration, forward until release, then retry
        vec("la0", 1'b1, 1'b1, 1'b0, 1'b0);
        vec("la1", 1'b0, 1'b1, 1'b1, 1'b1);
        vec("la2", 1'b0, 1'b1, 1'b0, 1'b1);
        vec("la3", 1'b1, 1'b1, 1'b1, 1'b1);
        vec("la4", 1'b1, 1'b1, 1'b1, 1'b1);
        vec("la5", 1'b1, 1'b1, 1'b1, 1'b1);
        wq[0] = 32'h12345678;
        do_tx(8'h3C, 1, 1, 1'b0);

        wq[0] = 32'hFFFFFFFF;
        do_tx(8'h81, 1, 1, 1'b1);

        // reset while address bit 5 is on the wire
        addr = 8'hFF;
        req  = 1'b1;
        in_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_out", 32'(out_b), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        req = 1'b0;
        #1;
        check("mid_out_noreq", 32'(out_b), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ndone_rst = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) ndone_rst++;
            @(posedge clk);
            #1;
        end
        check("post_rst_done", ndone_rst, 0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ulpb_tx_node.md
Name: ulpb_tx_node

Overview:
- Parametrised ring-bus node that arbitrates for the ULPB ring and serialises an address plus an unbounded stream of DATA_WIDTH words, MSB first.
- Ends each transfer with an end-of-TX marker, waits for a bounded ACK window, and returns to forwarding.
- Generalises the first-generation node in four ways: width-generic counters, a valid/ready word stream instead of fixed DATA1/DATA2, ACK timeout with status, and lost-arbitration forwarding.
- Sits between the upstream ring segment (IN), the downstream segment (OUT) and the local layer controller.

Parameters:
- ADDR_WIDTH, 8, address bits sent after arbitration.
- DATA_WIDTH, 32, bits per data word.
- ACK_TIMEOUT, 16, WAIT_ACK cycles before TX_FAIL; must be ≥1.
- BITCNT_WIDTH, clog2(max(ADDR_WIDTH,DATA_WIDTH)), bit-position counter width.

Ports:
- CLK  in  1  bus clock.
- RESET  in  1  asynchronous, active-high reset.
- IN  in  1  ring input from the upstream node.
- OUT  out  1  ring output to the downstream node.
- REQ_TX  in  1  local transmit request; level, held until TX_DONE.
- ADDR  in  ADDR_WIDTH  destination address; sampled on arbitration win.
- TX_DATA  in  DATA_WIDTH  data word.
- TX_VALID  in  1  TX_DATA/TX_LAST valid.
- TX_LAST  in  1  current word is the final word.
- TX_READY  out  1  word accepted this cycle (when TX_VALID=1).
- TX_DONE  out  1  one-cycle pulse; transfer finished.
- TX_ACKED  out  1  valid with TX_DONE; 1 = ACK seen.
- TX_FAIL  out  1  valid with TX_DONE; 1 = ACK timeout or data underflow.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- State register: IDLE, ARB, ADDR_DRIVE, ADDR_LATCH, DATA_DRIVE, DATA_LATCH, END_OF_TX, WAIT_ACK, FWD, BUS_RESET.
- Reset (async, RESET=1): state=IDLE, bit_out=1, counters=0, TX_READY=0, TX_DONE=0, TX_ACKED=0, TX_FAIL=0, BUSY=0.
- OUT is combinational on state:
  - IDLE: IN & ~REQ_TX
  - FWD: IN
  - END_OF_TX: 0
  - WAIT_ACK: 1
  - BUS_RESET: 1
  - all other states: bit_out
- IDLE:
  - IN=0 and REQ_TX=0 → FWD.
  - REQ_TX=1 → ARB.
  - Otherwise stay in IDLE.
- ARB:
  - IN=1 → win: latch ADDR, set bitpos=ADDR_WIDTH-1, go to ADDR_DRIVE.
  - IN=0 → lose: go to FWD. REQ_TX stays pending; the node retries after the next IDLE.
- Bit timing: each bit takes 2 cycles (DRIVE, then LATCH). In DRIVE, bit_out←selected bit at bitpos. In LATCH, bit_out holds.
- ADDR_LATCH:
  - bitpos≠0 → decrement, go to ADDR_DRIVE.
  - bitpos=0 → word fetch (below).
- Word fetch: TX_READY=1 combinationally in the fetch cycle.
  - TX_VALID=1 → latch TX_DATA and TX_LAST, bitpos=DATA_WIDTH-1, go to DATA_DRIVE.
  - TX_VALID=0 → underflow: set the fail flag, go to END_OF_TX.
- DATA_LATCH:
  - bitpos≠0 → decrement, go to DATA_DRIVE.
  - bitpos=0 and the latched last flag=1 → END_OF_TX.
  - bitpos=0 and last flag=0 → word fetch.
- END_OF_TX: 1 cycle, then WAIT_ACK with ack_cnt=0.
- WAIT_ACK:
  - IN=0 → record acked, go to BUS_RESET.
  - ack_cnt=ACK_TIMEOUT-1 → record fail, go to BUS_RESET.
  - Otherwise ack_cnt++.
- FWD: OUT=IN. Leave only when IN has been high for 2 consecutive cycles (bus release), then go to BUS_RESET.
- BUS_RESET: 1 cycle, then IDLE.
  - TX_DONE pulses on entry to BUS_RESET, only when this node transmitted.
  - TX_ACKED and TX_FAIL are mutually exclusive and valid only while TX_DONE=1.
- Timing: latency from the ARB win to the first address bit on OUT is 1 cycle. A transfer of N words occupies 1 + 2·ADDR_WIDTH + 2·N·DATA_WIDTH + 1 + ack-wait + 1 cycles.
- Simultaneous IN=0 and timeout in WAIT_ACK: ACK wins.
- REQ_TX dropped mid-transfer: ignored; the transfer completes.
- RESET mid-transfer: immediately IDLE, OUT reverts to IN & ~REQ_TX. No TX_DONE is issued.
- Counters saturate at the terminal values only; no wrap-around is observable.

Optional Feature:
- ULPB_TX_PARITY_EN defined: after each word's bit 0, one extra DRIVE/LATCH pair sends even parity of that word (XOR of all DATA_WIDTH bits) before the next fetch or END_OF_TX. This adds 2 cycles per word.
- ULPB_TX_PARITY_EN undefined: no parity bit, and no parity logic is synthesised.

Test Plan:
- Idle pass-through: REQ_TX=0, toggle IN 1,0,1,1 → OUT mirrors IN; state goes FWD then BUS_RESET then IDLE; BUSY is low only in IDLE; TX_DONE never pulses.
- Single word, ACK: ADDR=0xA5, TX_DATA=0xDEADBEEF with TX_LAST=1, IN held 1 until WAIT_ACK, then IN=0 on WAIT_ACK cycle 3 → OUT serialises 10100101 then DEADBEEF MSB-first at 2 cycles/bit, then a single 0 cycle; TX_DONE=1 with TX_ACKED=1 and TX_FAIL=0.
- Three-word stream: words 0x1, 0x2, 0x80000000 with TX_LAST on the third; TX_VALID always 1 → TX_READY pulses exactly 3 times, 64 cycles apart; the bitstream matches.
- ACK timeout: ACK_TIMEOUT=16, IN stays 1 through WAIT_ACK → TX_DONE exactly 16 cycles after WAIT_ACK entry, with TX_FAIL=1 and TX_ACKED=0.
- Lost arbitration: REQ_TX=1 with upstream driving IN=0 in ARB → FWD, OUT=IN, no TX_READY; after IN=1 for 2 cycles → IDLE → ARB retry wins.
- Underflow and reset: TX_VALID=0 at the first fetch → END_OF_TX, then TX_DONE with TX_FAIL=1. Separately, assert RESET during bit 5 of the address → next cycle state=IDLE, OUT=IN & ~REQ_TX, no TX_DONE.
